// File: rtl/dct_pkg.sv
// Shared constants and state encoding for the row-column 8x8 DCT sequencer.
// N is fixed by the 8-point datapath; LAT_DEFAULT matches the standard datapath depth.
package dct_pkg;
    localparam int N           = 8;
    localparam int LAT_DEFAULT = 4;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = $clog2(N + 8);

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        COL,
        DONE
    } state_t;
endpackage

// File: rtl/dct_pass_cnt.sv
// Pass counter shared by the row and column passes; terminal flag at N+LAT-1.
// Feed strobe while cnt<N, capture strobe once cnt>=LAT; indices read 0 when their strobe is low.
module dct_pass_cnt
    import dct_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic             last,
    output logic             feed,
    output logic [IDX_W-1:0] feed_idx,
    output logic             cap,
    output logic [IDX_W-1:0] cap_idx
);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N + LAT - 1);
    localparam logic [CNT_W-1:0] N_C    = CNT_W'(N);
    localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(LAT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last     = (cnt == LAST_C);
    assign feed     = (cnt < N_C);
    assign feed_idx = feed ? IDX_W'(cnt) : '0;
    // Capture index trails the feed index by exactly the datapath depth.
    assign cap      = (cnt >= LAT_C);
    assign cap_idx  = cap ? IDX_W'(cnt - LAT_C) : '0;
endmodule

// File: rtl/dct2d_seq.sv
// Row/column sequencer for one shared 8-point DCT; done pulses 2N+2*LAT cycles after row 0 is accepted.
// in_ready only while row beats are being fed; a mid-block input gap aborts the block; no output backpressure.
module dct2d_seq
    import dct_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             err_clr,
    output logic             dct_load,
    output logic             src_sel,
    output logic [IDX_W-1:0] feed_idx,
    output logic             buf_we,
    output logic [IDX_W-1:0] wr_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             dct_clr
);
    state_t           state;
    state_t           state_nxt;
    logic             run;
    logic             abort;
    logic             cnt_clr;
    logic             cnt_en;
    logic             last;
    logic             feed;
    logic             cap;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] c_idx;

    dct_pass_cnt #(.LAT(LAT)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .last     (last),
        .feed     (feed),
        .feed_idx (f_idx),
        .cap      (cap),
        .cap_idx  (c_idx)
    );

    // run keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            run     <= 1'b0;
            err     <= 1'b0;
            dct_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            run     <= 1'b1;
            dct_clr <= abort;
            if (abort) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        dct_load  = 1'b0;
        src_sel   = 1'b0;
        feed_idx  = '0;
        buf_we    = 1'b0;
        wr_idx    = '0;
        out_valid = 1'b0;
        out_idx   = '0;
        done      = 1'b0;
        abort     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = run;
                cnt_clr  = 1'b1;
                if (run && in_valid) begin
                    dct_load  = 1'b1;
                    feed_idx  = f_idx;
                    cnt_clr   = 1'b0;
                    cnt_en    = 1'b1;
                    state_nxt = ROW;
                end
            end
            ROW: begin
                dct_load = 1'b1;
                in_ready = feed;
                feed_idx = f_idx;
                buf_we   = cap;
                wr_idx   = c_idx;
                if (feed && !in_valid) begin
                    abort     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (last) begin
                    cnt_clr   = 1'b1;
                    state_nxt = COL;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            COL: begin
                dct_load  = 1'b1;
                src_sel   = 1'b1;
                feed_idx  = f_idx;
                out_valid = cap;
                out_idx   = c_idx;
                if (last) begin
                    cnt_clr   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_dct2d_seq.sv
// Directed bench for dct2d_seq: three instances (LAT 4, 1, 8) sharing clock, reset and err_clr.
// Each output vector packs {in_ready,dct_load,src_sel,feed_idx,buf_we,wr_idx,out_valid,out_idx,busy,done,err,dct_clr}.
module tb_dct2d_seq;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic       iv [3];
    logic       rdy[3], ld[3], ss[3], bw[3], ov[3], bs[3], dn[3], er[3], dc[3];
    logic [2:0] fi [3], wi[3], oi[3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
        dct2d_seq #(.LAT(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (rdy[g]),
            .err_clr   (err_clr),
            .dct_load  (ld[g]),
            .src_sel   (ss[g]),
            .feed_idx  (fi[g]),
            .buf_we    (bw[g]),
            .wr_idx    (wi[g]),
            .out_valid (ov[g]),
            .out_idx   (oi[g]),
            .busy      (bs[g]),
            .done      (dn[g]),
            .err       (er[g]),
            .dct_clr   (dc[g])
        );
    end

    function automatic logic [17:0] obs_vec(input int d);
        return {rdy[d], ld[d], ss[d], fi[d], bw[d], wi[d], ov[d], oi[d], bs[d], dn[d], er[d], dc[d]};
    endfunction

    // Expected outputs c cycles after row 0 is accepted (cycle 0 = accept cycle).
    function automatic logic [17:0] exp_vec(input int L, input int c, input logic e);
        int         t;
        logic       r, lo, s, b, o, dd, bz;
        logic [2:0] f, w, x;
        t  = 2 * N + 2 * L;
        r  = (c < N) || (c > t);
        lo = (c < t);
        s  = (c >= N + L) && (c < t);
        if (c < N)                             f = 3'(c);
        else if ((c >= N + L) && (c < 2*N+L))  f = 3'(c - N - L);
        else                                   f = 3'd0;
        b  = (c >= L) && (c < N + L);
        w  = b ? 3'(c - L) : 3'd0;
        o  = (c >= N + 2 * L) && (c < t);
        x  = o ? 3'(c - N - 2 * L) : 3'd0;
        bz = (c >= 1) && (c <= t);
        dd = (c == t);
        return {r, lo, s, f, b, w, o, x, bz, dd, e, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; err_clr = 1'b0;
        for (int d = 0; d < 3; d++) iv[d] = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (obs_vec(d) !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got %b expected %b", d, obs_vec(d), 18'd0);
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_first_clock: got %b expected 0", rdy[0]);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (rdy[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_release dut%0d: got %b expected 1", d, rdy[d]);
            end
        end
    endtask

    // Entered and left #1 after a rising edge with the selected DUT idle and ready.
    task automatic test_block(input int d, input int L, input logic e);
        for (int c = 0; c <= 2 * N + 2 * L + 1; c++) begin
            iv[d] = (c < N);
            @(negedge clk);
            n_checks++;
            if (obs_vec(d) !== exp_vec(L, c, e)) begin
                n_fail++;
                $display("FAIL block_lat%0d cycle %0d: got %b expected %b", L, c, obs_vec(d), exp_vec(L, c, e));
            end
            @(posedge clk); #1;
        end
        iv[d] = 1'b0;
    endtask

    task automatic test_gap();
        logic [17:0] e4, e5;
        e4 = {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        e5 = {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c <= 5; c++) begin
            iv[0] = (c < 3);
            @(negedge clk);
            n_checks++;
            if (c <= 3 && obs_vec(0) !== exp_vec(4, c, 1'b0)) begin
                n_fail++;
                $display("FAIL gap_rows cycle %0d: got %b expected %b", c, obs_vec(0), exp_vec(4, c, 1'b0));
            end else if (c == 4 && obs_vec(0) !== e4) begin
                n_fail++;
                $display("FAIL gap_abort cycle 4: got %b expected %b", obs_vec(0), e4);
            end else if (c == 5 && obs_vec(0) !== e5) begin
                n_fail++;
                $display("FAIL gap_after cycle 5: got %b expected %b", obs_vec(0), e5);
            end
            @(posedge clk); #1;
        end
        test_block(0, 4, 1'b1);
    endtask

    task automatic test_err_clr();
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({er[0], dc[0], bs[0]} !== 3'b110) begin
            n_fail++;
            $display("FAIL clr_with_gap err,dct_clr,busy: got %b expected 110", {er[0], dc[0], bs[0]});
        end
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (er[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_same_cycle err: got %b expected 1", er[0]);
        end
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({er[0], dc[0], rdy[0]} !== 3'b001) begin
            n_fail++;
            $display("FAIL clr_alone err,dct_clr,ready: got %b expected 001", {er[0], dc[0], rdy[0]});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 50; c++) begin
            iv[0] = (c < 33);
            @(negedge clk);
            n_checks++;
            if (obs_vec(0) !== exp_vec(4, c % 25, 1'b0)) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs_vec(0), exp_vec(4, c % 25, 1'b0));
            end
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lat_variants();
        test_block(1, 1, 1'b0);
        test_block(2, 8, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int c = 0; c <= 18; c++) begin
            iv[0] = (c < N);
            @(negedge clk);
            n_checks++;
            if (obs_vec(0) !== exp_vec(4, c, 1'b0)) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got %b expected %b", c, obs_vec(0), exp_vec(4, c, 1'b0));
            end
            if (c < 18) begin
                @(posedge clk); #1;
            end
        end
        #1 rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (obs_vec(d) !== 18'd0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got %b expected %b", d, obs_vec(d), 18'd0);
            end
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_async_release: got %b expected 0", rdy[0]);
        end
        @(posedge clk); #1;
        test_block(0, 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_block(0, 4, 1'b0);
        test_gap();
        test_err_clr();
        test_back_to_back();
        test_lat_variants();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
